piso_serializer: RTL and testbench

Parallel-in / serial-out transmitter that pairs with the team's 4-bit serial-to-parallel receiver. It accepts one WIDTH-bit word per valid/ready handshake and drives it out one bit per enabled clock, LSB first by default, with a framing strobe and a last-bit marker. Back-to-back words stream with no idle gap. It sits on the transmit side of the serial link, between a word producer and the serial wire.

---
 rtl/piso_serializer_if.sv | 25 ++
 rtl/piso_serializer.sv | 117 +++++++++++
 tb/tb_piso_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out link bundle between a word producer, the serializer and the serial wire.
// The producer-side modport drives the word and the bit-rate enable; the serializer drives the wire.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pdata;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sd;
  logic             sd_valid;
  logic             last;
  logic             busy;
  logic             done;

  modport master (
    output pdata, load_valid, shift_en,
    input  load_ready, sd, sd_valid, last, busy, done
  );

  modport slave (
    input  pdata, load_valid, shift_en,
    output load_ready, sd, sd_valid, last, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// PISO transmitter: first bit on sd the cycle after a load handshake, one bit per shift_en cycle.
// Backpressure: load_ready only in IDLE or while the final bit is consumed, so words stream gap-free.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sd_q, sd_d;
  logic             sd_valid_q, sd_valid_d;
  logic             done_q, done_d;

  logic             at_last;
  logic             load_ready;
  logic             load_hs;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Ready never looks at pdata, keeping the data path free of combinational loops.
  assign at_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign load_ready = !rst && ((state_q == IDLE) || (at_last && bus.shift_en));
  assign load_hs    = bus.load_valid && load_ready;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    sd_d       = sd_q;
    sd_valid_d = sd_valid_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_hs) begin
          state_d    = SHIFT;
          shreg_d    = bus.pdata;
          cnt_d      = '0;
          sd_d       = first_bit(bus.pdata);
          sd_valid_d = 1'b1;
        end else begin
          sd_d       = 1'b0;
          sd_valid_d = 1'b0;
        end
      end

      SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CW'(1);
            if (MSB_FIRST != 0) begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
              sd_d    = shreg_q[WIDTH-2];
            end else begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
              sd_d    = shreg_q[1];
            end
          end else begin
            done_d = 1'b1;
            if (load_hs) begin
              shreg_d    = bus.pdata;
              cnt_d      = '0;
              sd_d       = first_bit(bus.pdata);
              sd_valid_d = 1'b1;
            end else begin
              state_d    = IDLE;
              cnt_d      = '0;
              sd_d       = 1'b0;
              sd_valid_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      sd_q       <= 1'b0;
      sd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      sd_q       <= sd_d;
      sd_valid_q <= sd_valid_d;
      done_q     <= done_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sd         = sd_q;
  assign bus.sd_valid   = sd_valid_q;
  assign bus.last       = at_last;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an LSB-first and an MSB-first serializer with identical stimulus; a word-level model
// queues the expected bit stream and done pulses, and a monitor compares every cycle.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pdata;
  logic         load_valid;
  logic         shift_en;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) if_l ();
  piso_serializer_if #(.WIDTH(W)) if_m ();

  assign if_l.pdata = pdata;  assign if_l.load_valid = load_valid;  assign if_l.shift_en = shift_en;
  assign if_m.pdata = pdata;  assign if_m.load_valid = load_valid;  assign if_m.shift_en = shift_en;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(if_l));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(if_m));

  typedef struct {
    bit b_lsb;
    bit b_msb;
    bit lst;
  } exp_bit_t;

  exp_bit_t bitq[$];
  bit       doneq[$];
  int       rem = 0;
  bit       mon_en = 0;
  int       n_vec = 0;
  int       n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model learns the word-level outcome at the rising edge.
  task automatic cyc(input bit r, input bit lv, input logic [W-1:0] pd, input bit se, output bit acc);
    bit rdy;
    bit dn;
    @(negedge clk);
    rst = r; load_valid = lv; pdata = pd; shift_en = se;
    rdy = !r && (rem == 0 || (se && rem == 1));
    #1;
    chk("load_ready", {30'd0, if_l.load_ready, if_m.load_ready}, {30'd0, rdy, rdy});
    @(posedge clk);
    acc = 1'b0;
    if (r) begin
      bitq.delete();
      rem = 0;
      doneq.push_back(1'b0);
      mon_en = 1'b1;
    end else begin
      dn = 1'b0;
      if (rem > 0 && se) begin
        rem--;
        if (rem == 0) dn = 1'b1;
      end
      if (lv && rdy) begin
        acc = 1'b1;
        for (int k = 0; k < W; k++) begin
          exp_bit_t e;
          e.b_lsb = pd[k];
          e.b_msb = pd[W-1-k];
          e.lst   = (k == W - 1);
          bitq.push_back(e);
        end
        rem = W;
      end
      doneq.push_back(dn);
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 3 * W && !acc; t++) cyc(1'b0, 1'b1, w, 1'b1, acc);
    chk("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) cyc(1'b0, 1'b0, '0, 1'b1, acc);
  endtask

  initial begin : monitor
    exp_bit_t e;
    bit       ev;
    bit       d;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (doneq.size() != 0) begin
          d = doneq.pop_front();
          chk("done", {30'd0, if_l.done, if_m.done}, {30'd0, d, d});
        end
        ev = (bitq.size() != 0);
        chk("valid_busy", {28'd0, if_l.sd_valid, if_m.sd_valid, if_l.busy, if_m.busy}, {28'd0, {4{ev}}});
        if (ev) begin
          e = bitq[0];
          chk("sd_last", {28'd0, if_l.sd, if_m.sd, if_l.last, if_m.last},
              {28'd0, e.b_lsb, e.b_msb, e.lst, e.lst});
          if (shift_en && !rst) void'(bitq.pop_front());
        end else begin
          chk("idle_sd_last", {28'd0, if_l.sd, if_m.sd, if_l.last, if_m.last}, 32'd0);
        end
      end
    end
  end

  initial begin : driver
    bit           acc;
    bit           pend;
    logic [W-1:0] word;
    rst = 1'b1; load_valid = 1'b0; pdata = '0; shift_en = 1'b0;

    // Reset with a word on offer: nothing must load.
    cyc(1'b1, 1'b1, 4'hF, 1'b1, acc);
    cyc(1'b1, 1'b1, 4'hF, 1'b1, acc);
    idle(1);

    send(4'b1011);
    idle(6);

    // Back-to-back: second word held until the final bit of the first is consumed.
    send(4'hA);
    send(4'h5);
    idle(6);

    send(4'b0110);
    cyc(1'b0, 1'b0, '0, 1'b1, acc);
    for (int t = 0; t < 3; t++) cyc(1'b0, 1'b0, '0, 1'b0, acc);
    idle(6);

    send(4'hC);
    idle(2);
    cyc(1'b1, 1'b0, '0, 1'b1, acc);
    idle(1);
    send(4'h3);
    idle(6);

    pend = 1'b0;
    word = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && ($urandom % 3 == 0)) begin
        pend = 1'b1;
        word = W'($urandom);
      end
      cyc(($urandom % 89) == 0, pend, word, ($urandom % 4) != 0, acc);
      if (acc || rst) pend = 1'b0;
    end

    idle(3 * W);
    chk("drained", bitq.size(), 32'd0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
